// File: rtl/mc_controller.sv
// Multicycle CPU control FSM; optional andi/ori path under MC_CTRL_IMM_LOGIC_EN.
// Latency 3-5 cycles per instruction; memory states stall on mem_ready, abort after MEM_TIMEOUT waits.
module mc_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic       immzext,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        IMMWB  = 4'd10,
`ifdef MC_CTRL_IMM_LOGIC_EN
        JUMP   = 4'd11,
        LOGIEX = 4'd12
`else
        JUMP   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_IMM_LOGIC_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif
    localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt;
    logic       wait_st;
    logic       timeout;

    assign wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout = wait_st && !mem_ready && (wait_cnt == TIMEOUT_CNT);
    assign state   = reset ? 4'd0 : state_q;

    // Any state change (including the timeout self-loop) re-arms the wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state_q <= state_d;
            if (timeout || (state_d != state_q))
                wait_cnt <= 4'd0;
            else if (wait_st && !mem_ready)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        pcen     = 1'b0;
        immzext  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (timeout) begin
                    bus_err = 1'b1;
                end else begin
                    irwrite = mem_ready;
                    pcen    = mem_ready;
                    if (mem_ready) state_d = DECODE;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef MC_CTRL_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: state_d = LOGIEX;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (timeout) begin
                    bus_err = 1'b1;
                    state_d = FETCH;
                end else if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (timeout) begin
                    bus_err = 1'b1;
                    state_d = FETCH;
                end else if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcen    = zero;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = IMMWB;
            end
            IMMWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = FETCH;
            end
`ifdef MC_CTRL_IMM_LOGIC_EN
            LOGIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
                immzext = 1'b1;
                state_d = IMMWB;
            end
`endif
            default: state_d = FETCH;
        endcase
        if (reset) begin
            iord     = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
            alusrca  = 1'b0;
            pcen     = 1'b0;
            immzext  = 1'b0;
            alusrcb  = 2'b00;
            pcsrc    = 2'b00;
            aluop    = 2'b00;
            illegal  = 1'b0;
            bus_err  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle state and control-vector checks against hand-built constants.
// Control vector order: iord memread memwrite irwrite regdst memtoreg regwrite alusrca pcen immzext illegal bus_err | alusrcb pcsrc aluop.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, pcen, immzext, illegal, bus_err;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;
    logic [17:0] ctl;

    int checks = 0;
    int errors = 0;

    localparam logic [17:0] C_ZERO = 18'b0;
    localparam logic [17:0] C_F1   = {12'b0101_0000_1000, 6'b01_00_00};
    localparam logic [17:0] C_F0   = {12'b0100_0000_0000, 6'b01_00_00};
    localparam logic [17:0] C_FTO  = {12'b0100_0000_0001, 6'b01_00_00};
    localparam logic [17:0] C_DEC  = {12'b0000_0000_0000, 6'b11_00_00};
    localparam logic [17:0] C_DECI = {12'b0000_0000_0010, 6'b11_00_00};
    localparam logic [17:0] C_MADR = {12'b0000_0001_0000, 6'b10_00_00};
    localparam logic [17:0] C_MRD  = {12'b1100_0000_0000, 6'b00_00_00};
    localparam logic [17:0] C_MWB  = {12'b0000_0110_0000, 6'b00_00_00};
    localparam logic [17:0] C_MWR  = {12'b1010_0000_0000, 6'b00_00_00};
    localparam logic [17:0] C_EXEC = {12'b0000_0001_0000, 6'b00_00_10};
    localparam logic [17:0] C_AWB  = {12'b0000_1010_0000, 6'b00_00_00};
    localparam logic [17:0] C_BR1  = {12'b0000_0001_1000, 6'b00_01_01};
    localparam logic [17:0] C_BR0  = {12'b0000_0001_0000, 6'b00_01_01};
    localparam logic [17:0] C_IWB  = {12'b0000_0010_0000, 6'b00_00_00};
    localparam logic [17:0] C_JMP  = {12'b0000_0000_1000, 6'b00_10_00};
`ifdef MC_CTRL_IMM_LOGIC_EN
    localparam logic [17:0] C_LOGI = {12'b0000_0001_0100, 6'b10_00_11};
`endif

    mc_controller #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .pcen(pcen), .immzext(immzext), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    assign ctl = {iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                  alusrca, pcen, immzext, illegal, bus_err, alusrcb, pcsrc, aluop};

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the current cycle at the falling edge, then move to just after the next rising edge.
    task automatic cyc(input logic [3:0] exp_st, input logic [17:0] exp_ctl, input string tag);
        @(negedge clk);
        chk({tag, "_state"}, {14'b0, state}, {14'b0, exp_st});
        chk({tag, "_ctl"}, ctl, exp_ctl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
        @(posedge clk);
        #1;
        cyc(4'd0, C_ZERO, "reset_hold");
        reset = 1'b0;

        // R-type: 0,1,6,7,0
        cyc(4'd0, C_F1, "r_fetch");
        cyc(4'd1, C_DEC, "r_decode");
        cyc(4'd6, C_EXEC, "r_exec");
        cyc(4'd7, C_AWB, "r_aluwb");

        // lw with three wait cycles in MEMRD; mem_ready is ignored in DECODE/MEMADR
        opcode = 6'b100011;
        cyc(4'd0, C_F1, "lw_fetch");
        mem_ready = 1'b0;
        cyc(4'd1, C_DEC, "lw_decode");
        cyc(4'd2, C_MADR, "lw_memadr");
        for (int i = 0; i < 3; i++) cyc(4'd3, C_MRD, "lw_memrd_wait");
        mem_ready = 1'b1;
        cyc(4'd3, C_MRD, "lw_memrd_done");
        cyc(4'd4, C_MWB, "lw_memwb");

        // sw
        opcode = 6'b101011;
        cyc(4'd0, C_F1, "sw_fetch");
        cyc(4'd1, C_DEC, "sw_decode");
        cyc(4'd2, C_MADR, "sw_memadr");
        cyc(4'd5, C_MWR, "sw_memwr");

        // beq taken, then not taken
        opcode = 6'b000100;
        cyc(4'd0, C_F1, "beq1_fetch");
        cyc(4'd1, C_DEC, "beq1_decode");
        zero = 1'b1;
        cyc(4'd8, C_BR1, "beq1_branch");
        zero = 1'b0;
        cyc(4'd0, C_F1, "beq0_fetch");
        cyc(4'd1, C_DEC, "beq0_decode");
        cyc(4'd8, C_BR0, "beq0_branch");

        // addi
        opcode = 6'b001000;
        cyc(4'd0, C_F1, "addi_fetch");
        cyc(4'd1, C_DEC, "addi_decode");
        cyc(4'd9, C_MADR, "addi_exec");
        cyc(4'd10, C_IWB, "addi_immwb");

        // j
        opcode = 6'b000010;
        cyc(4'd0, C_F1, "j_fetch");
        cyc(4'd1, C_DEC, "j_decode");
        cyc(4'd11, C_JMP, "j_jump");

        // ori
        opcode = 6'b001101;
        cyc(4'd0, C_F1, "ori_fetch");
`ifdef MC_CTRL_IMM_LOGIC_EN
        cyc(4'd1, C_DEC, "ori_decode");
        cyc(4'd12, C_LOGI, "ori_logiex");
        cyc(4'd10, C_IWB, "ori_immwb");
`else
        cyc(4'd1, C_DECI, "ori_illegal");
`endif

        // FETCH timeout: bus_err in the 16th waiting cycle, then FETCH restarts
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc(4'd0, C_F0, "to_wait");
        cyc(4'd0, C_FTO, "to_buserr");
        for (int i = 0; i < 15; i++) cyc(4'd0, C_F0, "to_rewait");
        // mem_ready in the timeout cycle completes normally
        opcode = 6'b000010;
        mem_ready = 1'b1;
        cyc(4'd0, C_F1, "to_priority");
        cyc(4'd1, C_DEC, "to_prio_decode");
        cyc(4'd11, C_JMP, "to_prio_jump");

        // reset during a stalled MEMWR
        opcode = 6'b101011;
        cyc(4'd0, C_F1, "rst_fetch");
        cyc(4'd1, C_DEC, "rst_decode");
        mem_ready = 1'b0;
        cyc(4'd2, C_MADR, "rst_memadr");
        cyc(4'd5, C_MWR, "rst_memwr");
        reset = 1'b1;
        cyc(4'd0, C_ZERO, "rst_in_memwr");
        reset = 1'b0;
        cyc(4'd0, C_F0, "rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
